// File: rtl/reset_seq_ctrl.sv
// Reset release sequencer: waits for a stable PLL lock, then releases the peripheral, memory
// and CPU resets in order. Lock loss, watchdog or software request re-runs the whole sequence.
module reset_seq_ctrl #(
    parameter int HOLD_CYCLES  = 32,
    parameter int LOCK_CYCLES  = 16,
    parameter int STAGE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       wdt_expire,
    input  logic       soft_rst_req,
    output logic       rst_periph,
    output logic       rst_mem,
    output logic       rst_cpu,
    output logic       seq_done,
    output logic [1:0] rst_cause,
    output logic [2:0] dbg_state
);

    localparam int MAX_HL = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int MAX_P  = (MAX_HL > STAGE_CYCLES) ? MAX_HL : STAGE_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);

    localparam logic [1:0] CAUSE_PLL  = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
    localparam logic [1:0] CAUSE_SOFT = 2'b11;

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_LOCK   = 3'd1,
        S_PERIPH = 3'd2,
        S_MEM    = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    cause_next;
    logic [1:0]    sync_q;
    logic          locked_s;

    assign locked_s  = sync_q[1];
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        cause_next = rst_cause;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next = S_LOCK;
                    cnt_next   = '0;
                end
            end
            S_LOCK: begin
                // Any unlocked cycle restarts the stability window.
                if (!locked_s) begin
                    cnt_next = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_next = S_PERIPH;
                    cnt_next   = '0;
                end
            end
            S_PERIPH, S_MEM: begin
                if (!locked_s) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                    cause_next = CAUSE_PLL;
                end else if (cnt == STAGE_LAST) begin
                    state_next = (state == S_PERIPH) ? S_MEM : S_RUN;
                    cnt_next   = '0;
                end
            end
            S_RUN: begin
                cnt_next = '0;
                if (!locked_s || wdt_expire || soft_rst_req) begin
                    state_next = S_HOLD;
                end
                if (!locked_s) begin
                    cause_next = CAUSE_PLL;
                end else if (wdt_expire) begin
                    cause_next = CAUSE_WDT;
                end else if (soft_rst_req) begin
                    cause_next = CAUSE_SOFT;
                end
            end
            default: begin
                state_next = S_HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so each release lands on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HOLD;
            cnt        <= '0;
            sync_q     <= 2'b00;
            rst_periph <= 1'b1;
            rst_mem    <= 1'b1;
            rst_cpu    <= 1'b1;
            seq_done   <= 1'b0;
            rst_cause  <= 2'b00;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            sync_q     <= {sync_q[0], pll_locked};
            rst_periph <= (state_next == S_HOLD) || (state_next == S_LOCK);
            rst_mem    <= (state_next != S_MEM) && (state_next != S_RUN);
            rst_cpu    <= (state_next != S_RUN);
            seq_done   <= (state_next == S_RUN);
            rst_cause  <= cause_next;
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: directed sequences with hand-computed edge numbers plus
// randomized lock/watchdog/software traffic checked every cycle against a behavioural model.
module tb_reset_seq_ctrl;

    localparam int HOLD  = 4;
    localparam int LOCK  = 4;
    localparam int STAGE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       wdt_expire = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       rst_periph;
    logic       rst_mem;
    logic       rst_cpu;
    logic       seq_done;
    logic [1:0] rst_cause;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;

    reset_seq_ctrl #(
        .HOLD_CYCLES (HOLD),
        .LOCK_CYCLES (LOCK),
        .STAGE_CYCLES(STAGE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .wdt_expire  (wdt_expire),
        .soft_rst_req(soft_rst_req),
        .rst_periph  (rst_periph),
        .rst_mem     (rst_mem),
        .rst_cpu     (rst_cpu),
        .seq_done    (seq_done),
        .rst_cause   (rst_cause),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model: count of released resets plus elapsed cycles in the current wait
    logic [1:0] m_sh;
    logic       m_ls;
    int         m_rel;
    int         m_age;
    bit         m_hold_done;
    logic [1:0] m_cause;
    logic [5:0] exp_q[$];
    logic [5:0] m_exp;

    function automatic logic [5:0] m_vec();
        return {(m_rel < 1), (m_rel < 2), (m_rel < 3), (m_rel == 3), m_cause};
    endfunction

    function automatic void m_restart(input logic [1:0] cause);
        m_rel       = 0;
        m_age       = 0;
        m_hold_done = 0;
        m_cause     = cause;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh = 2'b00;
            m_restart(2'b00);
        end else begin
            m_ls = m_sh[1];
            m_sh = {m_sh[0], pll_locked};
            if (m_rel == 3) begin
                if (!m_ls) m_restart(2'b01);
                else if (wdt_expire) m_restart(2'b10);
                else if (soft_rst_req) m_restart(2'b11);
            end else if (!m_hold_done) begin
                m_age++;
                if (m_age == HOLD) begin
                    m_hold_done = 1;
                    m_age = 0;
                end
            end else if (m_rel == 0) begin
                if (!m_ls) begin
                    m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == LOCK) begin
                        m_rel = 1;
                        m_age = 0;
                    end
                end
            end else begin
                if (!m_ls) begin
                    m_restart(2'b01);
                end else begin
                    m_age++;
                    if (m_age == STAGE) begin
                        m_rel++;
                        m_age = 0;
                    end
                end
            end
        end
        exp_q.push_back(m_vec());
    end

    // scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q[$];
            exp_q.delete();
            tests++;
            if ({rst_periph, rst_mem, rst_cpu, seq_done, rst_cause} !== m_exp) begin
                fails++;
                $display("FAIL model t=%0t got periph/mem/cpu/done/cause=%b expected=%b", $time,
                         {rst_periph, rst_mem, rst_cpu, seq_done, rst_cause}, m_exp);
            end
        end
    end

    // driver and directed-check tasks
    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_reset(input string name);
        check_int({name, "_periph"}, rst_periph, 1);
        check_int({name, "_mem"}, rst_mem, 1);
        check_int({name, "_cpu"}, rst_cpu, 1);
        check_int({name, "_done"}, seq_done, 0);
        check_int({name, "_cause"}, rst_cause, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_reset("async_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts edges from reset release; pll_locked goes low for one cycle after edge glitch_at.
    task automatic run_seq(input int glitch_at, output int tp, output int tm, output int tc,
                           output int td);
        tp = -1; tm = -1; tc = -1; td = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (tp < 0 && !rst_periph) tp = e;
            if (tm < 0 && !rst_mem) tm = e;
            if (tc < 0 && !rst_cpu) tc = e;
            if (td < 0 && seq_done) td = e;
            if (tc >= 0 && td >= 0) break;
            @(negedge clk);
            if (e == glitch_at) pll_locked = 1'b0;
            else if (e == glitch_at + 1) pll_locked = 1'b1;
        end
    endtask

    task automatic count_to_release(output int n);
        n = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (!rst_periph) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int ok;
        ok = 0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            #1;
            if (seq_done) begin
                ok = 1;
                break;
            end
        end
        check_int(name, ok, 1);
    endtask

    initial begin
        int tp, tm, tc, td, n;
        bit low_active;
        int low_left;

        // power-on reset with a stable PLL
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        check_all_reset("por");
        rst_n = 1'b1;
        run_seq(-10, tp, tm, tc, td);
        check_int("t1_periph_edge", tp, 8);
        check_int("t1_mem_edge", tm, 10);
        check_int("t1_cpu_edge", tc, 12);
        check_int("t1_done_edge", td, 12);
        check_int("t1_cause", rst_cause, 0);

        // one-cycle lock glitch at each S_LOCK position delays release by position+1
        for (int g = 0; g < LOCK; g++) begin
            apply_reset();
            run_seq(2 + g, tp, tm, tc, td);
            check_int("t2_glitch_periph_edge", tp, 9 + g);
            check_int("t2_glitch_cpu_edge", tc, 13 + g);
        end

        // software request from S_RUN
        @(negedge clk);
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check_int("t3_periph", rst_periph, 1);
        check_int("t3_mem", rst_mem, 1);
        check_int("t3_cpu", rst_cpu, 1);
        check_int("t3_done", seq_done, 0);
        check_int("t3_cause", rst_cause, 3);
        @(negedge clk);
        soft_rst_req = 1'b0;
        count_to_release(n);
        check_int("t3_release_delay", n, HOLD + LOCK);
        wait_done("t3_done_timeout");

        // simultaneous events: watchdog beats software
        @(negedge clk);
        wdt_expire = 1'b1;
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check_int("t4_wdt_cause", rst_cause, 2);
        check_int("t4_wdt_cpu", rst_cpu, 1);
        @(negedge clk);
        wdt_expire = 1'b0;
        soft_rst_req = 1'b0;
        wait_done("t4_done_timeout_a");

        // lock loss in the same cycle beats both
        @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wdt_expire = 1'b1;
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check_int("t4_pll_cause", rst_cause, 1);
        check_int("t4_pll_done", seq_done, 0);
        @(negedge clk);
        wdt_expire = 1'b0;
        soft_rst_req = 1'b0;
        pll_locked = 1'b1;
        wait_done("t4_done_timeout_b");

        // lock loss while in S_MEM
        apply_reset();
        count_to_release(n);
        check_int("t5_periph_edge", n, 8);
        @(negedge clk);
        pll_locked = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_int("t5_mem_entered", rst_mem, 0);
        @(posedge clk);
        #1;
        check_int("t5_periph_reassert", rst_periph, 1);
        check_int("t5_mem_reassert", rst_mem, 1);
        check_int("t5_cause", rst_cause, 1);
        @(negedge clk);
        pll_locked = 1'b1;
        wait_done("t5_resume_timeout");

        // rst_n pulse while in S_PERIPH
        @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        count_to_release(n);
        check_int("t6_pre_cause", rst_cause, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_reset("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_seq(-10, tp, tm, tc, td);
        check_int("t6_periph_edge", tp, 8);
        check_int("t6_mem_edge", tm, 10);
        check_int("t6_cpu_edge", tc, 12);
        check_int("t6_done_edge", td, 12);

        // randomized traffic, checked by the scoreboard every cycle
        low_active = 0;
        low_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wdt_expire   = ($urandom_range(0, 29) == 0);
            soft_rst_req = ($urandom_range(0, 29) == 0);
            if (low_active) begin
                low_left--;
                if (low_left == 0) begin
                    low_active = 0;
                    pll_locked = 1'b1;
                end
            end else if ($urandom_range(0, 99) == 0) begin
                low_active = 1;
                low_left = $urandom_range(1, 6);
                pll_locked = 1'b0;
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        wdt_expire = 1'b0;
        soft_rst_req = 1'b0;
        pll_locked = 1'b1;
        wait_done("final_done_timeout");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
